commutator_postdelay: RTL
=========================

# commutator_postdelay

Second half of the R2MDC inter-stage network. It takes the two aligned paths produced by the pre-delay stage, swaps them every DELAY valid samples (commutator), then delays the upper commuted path by DELAY valid samples so the next butterfly receives correctly paired operands. It sits between the pre-delay commutator output and the next stage's butterfly inputs, one instance per stage boundary.

## Interface
- DELAY, 16: commutator period and post-delay depth in valid samples; power of two, ≥2
- DATA_W, 16: width of each real/imag component
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- in_valid  in  1  current cm_in* sample pair is valid
- cm_in0_re, cm_in0_im  in  DATA_W each  path 0 input
- cm_in1_re, cm_in1_im  in  DATA_W each  path 1 input
- bf_in0_re, bf_in0_im  out  DATA_W each  delayed path to next butterfly, registered
- bf_in1_re, bf_in1_im  out  DATA_W each  undelayed path to next butterfly, registered
- out_valid  out  1  bf_in* pair is valid, registered
- sw_state  out  1  current commutator position (0 straight, 1 crossed), registered

## Operation
- State: sample counter cnt (CNT_W = $clog2(DELAY) bits), switch bit sw, fill flag primed, circular buffer mem[0:DELAY-1] holding re/im of DATA_W each.
- Commutator, combinational on inputs: sw=0 -> a=in0, b=in1; sw=1 -> a=in1, b=in0.
- On each cycle with in_valid=1:
  - read mem[cnt] (value written DELAY valid samples earlier), then write a into mem[cnt] (read-before-write, same address).
  - bf_in0 <= read value; bf_in1 <= b; sw_state <= sw.
  - out_valid <= primed.
  - cnt <= cnt+1 (wraps naturally at DELAY); when cnt==DELAY-1: sw <= ~sw, primed <= 1.
- On cycles with in_valid=0: cnt, sw, primed, mem unchanged; out_valid <= 0; bf_in* and sw_state hold.
- Stalls (in_valid gaps) of any length are legal; pairing is defined in valid-sample order, not cycles.
- Output for valid sample k (k ≥ DELAY): bf_in0 = a[k-DELAY], bf_in1 = b[k].
- primed never clears except by reset; continuous frames stream back-to-back with no bubble.
- Arithmetic: none on data; cnt is unsigned modulo DELAY; no saturation concerns.

## Timing
- Latency: 1 cycle from valid input sample to its bf_in1 appearance; bf_in0 carries path a from DELAY valid samples earlier.
- First out_valid: cycle after valid sample index DELAY (0-based) is presented; samples 0..DELAY-1 produce out_valid=0.
- sw toggles at the clock edge consuming valid sample index DELAY-1 mod DELAY; sample DELAY uses new sw.
- Reset (async assert, any time incl. mid-frame): bf_in*=0, out_valid=0, sw_state=0, cnt=0, sw=0, primed=0 immediately; mem contents not reset and never observable because primed=0 gates out_valid.
- Reset deassertion: first valid sample after release is index 0 of a new frame.
- Simultaneous wrap and stall: wrap occurs only on a valid sample; a stall at cnt==DELAY-1 defers the toggle until that sample arrives.

## Test plan
- DELAY=4, continuous valid, in0=k, in1=100+k, k=0..15 -> out_valid low for outputs of k=0..3; then (bf_in0,bf_in1) = (0,4),(1,5),(2,6),(3,7),(104,108),(105,109),(106,110),(107,111),(8,12),(9,13),(10,14),(11,15); imag parts mirror with distinct ramp.
- Same stimulus with in_valid=0 inserted for 3 cycles after k=5 and 1 cycle after k=7 -> identical output pair sequence; out_valid low exactly on stall-following cycles; sw_state toggles only on valid samples.
- RST_N pulsed low asynchronously (mid-cycle) at k=9 -> outputs, out_valid, sw_state go 0 without clock edge; restart ramp from k=0 reproduces first-scenario sequence exactly.
- Back-to-back frames, 64 continuous samples, DELAY=16 -> out_valid stays high from sample 16 onward with no gap; sw_state period 32 valid samples.
- Extreme values 0x8000/0x7FFF on all components -> passed bit-exact, no sign or width corruption.
- DELAY=2 -> pairs (0,2),(1,3),(102,104),(103,105),(4,6)… with in0=k, in1=100+k.

Source files
------------

// File: rtl/commutator_postdelay.sv
// R2MDC post-delay commutator: swaps the two paths every DELAY valid samples,
// then delays the upper commuted path by DELAY valid samples.
module commutator_postdelay #(
  parameter int DELAY  = 16,
  parameter int DATA_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] cm_in0_re,
  input  logic signed [DATA_W-1:0] cm_in0_im,
  input  logic signed [DATA_W-1:0] cm_in1_re,
  input  logic signed [DATA_W-1:0] cm_in1_im,
  output logic signed [DATA_W-1:0] bf_in0_re,
  output logic signed [DATA_W-1:0] bf_in0_im,
  output logic signed [DATA_W-1:0] bf_in1_re,
  output logic signed [DATA_W-1:0] bf_in1_im,
  output logic                     out_valid,
  output logic                     sw_state
);

  localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;

  logic [CNT_W-1:0]         cnt;
  logic                     sw;
  logic                     primed;
  logic signed [DATA_W-1:0] mem_re [DELAY];
  logic signed [DATA_W-1:0] mem_im [DELAY];
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;

  always_comb begin
    a_re = cm_in0_re;
    a_im = cm_in0_im;
    b_re = cm_in1_re;
    b_im = cm_in1_im;
    if (sw) begin
      a_re = cm_in1_re;
      a_im = cm_in1_im;
      b_re = cm_in0_re;
      b_im = cm_in0_im;
    end
  end

  // Output stage: mem is read here before the same-address write below lands.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt       <= '0;
      sw        <= 1'b0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      sw_state  <= 1'b0;
      bf_in0_re <= '0;
      bf_in0_im <= '0;
      bf_in1_re <= '0;
      bf_in1_im <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        bf_in0_re <= mem_re[cnt];
        bf_in0_im <= mem_im[cnt];
        bf_in1_re <= b_re;
        bf_in1_im <= b_im;
        sw_state  <= sw;
        out_valid <= primed;
        cnt       <= cnt + 1'b1;
        // DELAY is a power of two, so all-ones marks the last sample of a period.
        if (&cnt) begin
          sw     <= ~sw;
          primed <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (in_valid) begin
      mem_re[cnt] <= a_re;
      mem_im[cnt] <= a_im;
    end
  end

endmodule
